bcd_countdown_timer: RTL and testbench
======================================

// Module: bcd_countdown_timer
// PURPOSE
//   Two-digit BCD countdown timer (99..00) that drives the dual seven-segment display decoder directly.
//   - ones_out carries the ones digit: bits [3:0] are the digit, bits [7:4] are always zero.
//   - tens_out carries the tens digit; the display decoder blanks the tens display when tens_out is 0.
//   - Preset is loaded from switches; an internal prescaler decrements the count at TICK_HZ.
// PARAMETERS
//   CLK_HZ   50_000_000  input clock frequency in Hz
//   TICK_HZ  1           decrement rate in Hz; DIV = CLK_HZ/TICK_HZ, must be >= 2
// PORTS
//   clk          in   1  system clock, rising edge
//   rst_n        in   1  asynchronous active-low reset
//   load         in   1  1-cycle pulse: capture preset_tens/preset_ones, go to IDLE
//   start        in   1  1-cycle pulse: begin or resume counting
//   pause        in   1  1-cycle pulse: freeze count while running
//   preset_tens  in   4  BCD preset, tens digit
//   preset_ones  in   4  BCD preset, ones digit
//   ones_out     out  8  {4'b0000, ones BCD digit}
//   tens_out     out  4  tens BCD digit
//   running      out  1  high in RUN state
//   done         out  1  1-cycle pulse when the count reaches 00
// BEHAVIOUR
//   - Reset values: ones_out=0, tens_out=0, running=0, done=0, prescaler=0, preset regs=0, state=IDLE.
//   - Input clamping: any preset digit > 9 is clamped to 9 when captured (0xF -> 9).
//   - Input priority in the same cycle: load > start > pause.
//   - Prescaler:
//     - Counts 0..DIV-1 only in RUN; tick asserts when it equals DIV-1, then it wraps to 0.
//     - Cleared on load and on IDLE->RUN; held (not cleared) in PAUSE.
//   - State machine (registered outputs, 1-cycle latency from input pulse):
//     - IDLE:  start with count != 00 -> RUN. start with count == 00 -> DONE, done=1 next cycle.
//     - RUN:   on tick, decrement. pause -> PAUSE. load -> IDLE with new preset.
//     - PAUSE: start -> RUN with prescaler phase preserved. load -> IDLE.
//     - DONE:  count holds 00, running=0. load -> IDLE. start is ignored.
//   - load in any state: count <= clamped preset and state <= IDLE, even mid-run.
//   - Decrement rule:
//     - ones != 0: ones - 1.
//     - ones == 0: ones <= 9, tens - 1.
//     - The result never goes below 00.
//   - Reaching 00: on the tick that produces 00, state <= DONE and done pulses for exactly 1 cycle.
//   - done is never high in two consecutive cycles.
//   - Asserting rst_n mid-count aborts immediately to reset values; the stored preset is lost.
// CONFIGURATION
//   WRAP_RELOAD_EN defined:
//     - On reaching 00, done still pulses, but the count reloads the stored preset on the same edge.
//     - State stays RUN and the prescaler continues; DONE is unreachable from RUN.
//     - Preset 00 still goes IDLE->DONE.
//   WRAP_RELOAD_EN undefined: stop in DONE as described above.
// STRUCTURE
//   - timer_pkg: state enum {IDLE,RUN,PAUSE,DONE}; BCD_MAX=4'd9; function bcd_clamp(4b)->4b.
//   - Sub-module tick_prescaler (CLK_HZ, TICK_HZ; ports clk, rst_n, en, clr, tick) owns the $clog2(DIV) counter.
//   - Top level holds the FSM, the BCD digit registers and the preset registers.
// TESTING (sim with CLK_HZ=10, TICK_HZ=1 -> DIV=10)
//   1. Reset: rst_n low 3 cycles -> ones_out=8'h00, tens_out=0, running=0, done=0; start alone -> DONE, done pulse.
//   2. Countdown: load 1/2, start -> running=1; 12->11 after 10 cycles, 10->09 (ones=9, tens=0) after 30,
//      00 after 120 with a single done pulse and running=0.
//   3. Pause: preset 05, start, pause at cycle 15 (count 04), hold 50 cycles -> stays 04;
//      start -> 03 exactly 5 cycles later (phase preserved).
//   4. Clamp: preset_tens=4'hA, preset_ones=4'hF, load -> tens_out=9, ones_out=8'h09.
//   5. Load mid-run: preset 30, start, load 0/7 at cycle 25 -> IDLE, count 07, running=0, no done pulse.
//   6. WRAP_RELOAD_EN: preset 02, start -> after 20 cycles done pulses, count=02, running stays 1; repeats every 20.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and helpers for the two-digit BCD countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Switch inputs can present non-BCD codes; saturate them to 9.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk by CLK_HZ/TICK_HZ; tick is high on the last count of each period while enabled.
module tick_prescaler #(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD countdown timer (99..00) feeding the seven-segment decoder.
// Optional build macro: WRAP_RELOAD_EN (reload stored preset on reaching 00 instead of stopping).
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       start,
  input  logic       pause,
  input  logic [3:0] preset_tens,
  input  logic [3:0] preset_ones,
  output logic [7:0] ones_out,
  output logic [3:0] tens_out,
  output logic       running,
  output logic       done
);

  state_t     state, state_nxt;
  logic [3:0] tens_q, ones_q, tens_d, ones_d;
  logic [3:0] ptens_q, pones_q, ptens_d, pones_d;
  logic       done_q, done_d, running_q, running_d;
  logic       tick, pre_clr, is_zero, at_one;

  assign is_zero = (tens_q == 4'd0) && (ones_q == 4'd0);
  assign at_one  = (tens_q == 4'd0) && (ones_q == 4'd1);
  assign pre_clr = load || ((state == IDLE) && start && !is_zero);

  tick_prescaler #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state == RUN),
    .clr  (pre_clr),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tens_q    <= '0;
      ones_q    <= '0;
      ptens_q   <= '0;
      pones_q   <= '0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      ptens_q   <= ptens_d;
      pones_q   <= pones_d;
      done_q    <= done_d;
      running_q <= running_d;
    end
  end

  always_comb begin
    state_nxt = state;
    if (load) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:  if (start) state_nxt = is_zero ? DONE : RUN;
        RUN: begin
          // A tick landing on 00 takes precedence over a same-cycle pause.
`ifdef WRAP_RELOAD_EN
          if (pause) state_nxt = PAUSE;
`else
          if (tick && at_one) state_nxt = DONE;
          else if (pause)     state_nxt = PAUSE;
`endif
        end
        PAUSE: if (start) state_nxt = RUN;
        DONE:  state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    tens_d  = tens_q;
    ones_d  = ones_q;
    ptens_d = ptens_q;
    pones_d = pones_q;
    done_d  = 1'b0;
    if (load) begin
      ptens_d = bcd_clamp(preset_tens);
      pones_d = bcd_clamp(preset_ones);
      tens_d  = bcd_clamp(preset_tens);
      ones_d  = bcd_clamp(preset_ones);
    end else if ((state == IDLE) && start && is_zero) begin
      done_d = 1'b1;
    end else if ((state == RUN) && tick) begin
      if (at_one) begin
        done_d = 1'b1;
`ifdef WRAP_RELOAD_EN
        tens_d = ptens_q;
        ones_d = pones_q;
`else
        tens_d = '0;
        ones_d = '0;
`endif
      end else if (ones_q != 4'd0) begin
        ones_d = ones_q - 4'd1;
      end else if (tens_q != 4'd0) begin
        ones_d = BCD_MAX;
        tens_d = tens_q - 4'd1;
      end
    end
    running_d = (state_nxt == RUN);
  end

  assign ones_out = {4'b0000, ones_q};
  assign tens_out = tens_q;
  assign running  = running_q;
  assign done     = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench for bcd_countdown_timer with a decimal reference model (DIV = 10).
module tb_bcd_countdown_timer;

  localparam int DIV = 10;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0, start = 1'b0, pause = 1'b0;
  logic [3:0] preset_tens = '0, preset_ones = '0;
  logic [7:0] ones_out;
  logic [3:0] tens_out;
  logic       running, done;

  bcd_countdown_timer #(.CLK_HZ(10), .TICK_HZ(1)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .start(start), .pause(pause),
    .preset_tens(preset_tens), .preset_ones(preset_ones),
    .ones_out(ones_out), .tens_out(tens_out), .running(running), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] ones;
    logic [3:0] tens;
    logic       run;
    logic       dn;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: count as a plain integer 0..99.
  int m_val = 0, m_preset = 0, m_phase = 0, m_mode = M_IDLE;

  function automatic int clampd(input logic [3:0] d);
    return (d > 4'd9) ? 9 : int'(d);
  endfunction

  task automatic step(input bit rst, input bit ld, input bit st, input bit ps,
                      input logic [3:0] pt, input logic [3:0] po);
    exp_t e;
    bit   tick, dn;
    @(negedge clk);
    rst_n = !rst; load = ld; start = st; pause = ps;
    preset_tens = pt; preset_ones = po;
    dn = 1'b0;
    if (rst) begin
      m_val = 0; m_preset = 0; m_phase = 0; m_mode = M_IDLE;
    end else begin
      tick = (m_mode == M_RUN) && (m_phase == DIV - 1);
      if (ld) m_phase = 0;
      else if (m_mode == M_IDLE && st && m_val != 0) m_phase = 0;
      else if (m_mode == M_RUN) m_phase = (m_phase + 1) % DIV;
      if (ld) begin
        m_val = clampd(pt) * 10 + clampd(po);
        m_preset = m_val;
        m_mode = M_IDLE;
      end else begin
        case (m_mode)
          M_IDLE: if (st) begin
            if (m_val == 0) begin m_mode = M_DONE; dn = 1'b1; end
            else m_mode = M_RUN;
          end
          M_RUN: begin
            if (tick && m_val > 0) begin
              m_val = m_val - 1;
              if (m_val == 0) begin
                dn = 1'b1;
`ifdef WRAP_RELOAD_EN
                m_val = m_preset;
`else
                m_mode = M_DONE;
`endif
              end
            end
            if (m_mode == M_RUN && ps) m_mode = M_PAUSE;
          end
          M_PAUSE: if (st) m_mode = M_RUN;
          default: ;
        endcase
      end
    end
    e.ones = 8'(m_val % 10);
    e.tens = 4'(m_val / 10);
    e.run  = (m_mode == M_RUN);
    e.dn   = dn;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 4'd0, 4'd0);
  endtask

  task automatic do_load(input logic [3:0] t, input logic [3:0] o);
    step(0, 1, 0, 0, t, o);
  endtask

  // Monitor: the DUT presents a result every cycle; compare one expectation per edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (ones_out !== e.ones || tens_out !== e.tens || running !== e.run || done !== e.dn) begin
        miscompares++;
        $display("FAIL vec%0d @%0t: got ones=%h tens=%h running=%b done=%b, expected ones=%h tens=%h running=%b done=%b",
                 vectors, $time, ones_out, tens_out, running, done, e.ones, e.tens, e.run, e.dn);
      end
    end
  end

  initial begin
    int r;
    // Reset, then start with count 00 goes straight to DONE
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 4'd0, 4'd0);
    step(0, 0, 1, 0, 4'd0, 4'd0);
    idle(3);
    // Full countdown from 12
    do_load(4'd1, 4'd2);
    step(0, 0, 1, 0, 4'd0, 4'd0);
    idle(125);
    // Pause holds count and prescaler phase
    do_load(4'd0, 4'd5);
    step(0, 0, 1, 0, 4'd0, 4'd0);
    idle(14);
    step(0, 0, 0, 1, 4'd0, 4'd0);
    idle(50);
    step(0, 0, 1, 0, 4'd0, 4'd0);
    idle(10);
    // Clamp of non-BCD presets
    do_load(4'hA, 4'hF);
    idle(2);
    // Load mid-run
    do_load(4'd3, 4'd0);
    step(0, 0, 1, 0, 4'd0, 4'd0);
    idle(24);
    do_load(4'd0, 4'd7);
    idle(15);
    // Priority: load beats start and pause in the same cycle
    step(0, 0, 1, 0, 4'd0, 4'd0);
    idle(3);
    step(0, 1, 1, 1, 4'd0, 4'd3);
    idle(3);
    // Reset mid-count loses the preset
    do_load(4'd2, 4'd0);
    step(0, 0, 1, 0, 4'd0, 4'd0);
    idle(30);
    step(1, 0, 0, 0, 4'd0, 4'd0);
    idle(2);
    step(0, 0, 1, 0, 4'd0, 4'd0);
    idle(3);
    // Randomized traffic
    for (int i = 0; i < 5000; i++) begin
      r = int'($urandom_range(0, 999));
      if (r < 2)
        step(1, 0, 0, 0, 4'd0, 4'd0);
      else if (r < 30)
        step(0, 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
             4'($urandom_range(0, 3) == 0 ? $urandom_range(0, 15) : $urandom_range(0, 1)),
             4'($urandom_range(0, 15)));
      else if (r < 90)
        step(0, 0, 1, $urandom_range(0, 3) == 0, 4'd0, 4'd0);
      else if (r < 120)
        step(0, 0, 0, 1, 4'd0, 4'd0);
      else
        idle(1);
    end
    @(negedge clk);
    rst_n = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
